// File: rtl/bram_loader_if.sv
// Byte-stream handshake bundle feeding the BRAM loader (valid/ready with last marker).
interface bram_loader_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bram_loader.sv
// Purpose: packs a byte stream little-endian into byte-enabled 32-bit BRAM port-B writes; BRAM_LOADER_CHECKSUM_EN adds a running word sum.
// Latency: write, done and word_count appear the cycle after the byte that completes a word or carries last.
// Backpressure: none while busy (1 byte/cycle, no bubbles); ready is low only while idle.
module bram_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  bram_loader_if.slave      s,
  output logic [3:0]        we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [31:0]       din_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
`ifdef BRAM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        idx;
  logic [3:0]        mask, mask_nx;
  logic [31:0]       word_acc, word_nx;
  logic              hs, wr_fire, ovf, start_acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    hs        = s.valid & s.ready;
    wr_fire   = 1'b0;
    ovf       = 1'b0;
    start_acc = 1'b0;
    word_nx   = word_acc;
    mask_nx   = mask;
    word_nx[{idx, 3'b000} +: 8] = s.data;
    mask_nx[idx]                = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        if (hs && (idx == 2'd3 || s.last)) begin
          wr_fire = 1'b1;
          if (s.last) begin
            state_nx = IDLE;
          end else if (ptr == PTR_MAX) begin
            // Full word landed on the last address: stop writing, swallow the rest.
            ovf      = 1'b1;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (hs && s.last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s.ready    <= 1'b0;
      we_b       <= '0;
      addr_b     <= '0;
      din_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      ptr        <= '0;
      idx        <= '0;
      mask       <= '0;
      word_acc   <= '0;
    end else begin
      we_b    <= '0;
      done    <= 1'b0;
      s.ready <= (state_nx != IDLE);
      busy    <= (state_nx != IDLE);
      if (start_acc) begin
        ptr        <= base_addr;
        idx        <= '0;
        mask       <= '0;
        word_acc   <= '0;
        word_count <= '0;
        err        <= 1'b0;
      end
      if (state == LOAD && hs) begin
        if (wr_fire) begin
          we_b       <= mask_nx;
          din_b      <= word_nx;
          addr_b     <= ptr;
          word_count <= word_count + 1'b1;
          idx        <= '0;
          mask       <= '0;
          word_acc   <= '0;
          if (!ovf) ptr <= ptr + 1'b1;
          if (ovf)    err  <= 1'b1;
          if (s.last) done <= 1'b1;
        end else begin
          idx      <= idx + 2'd1;
          mask     <= mask_nx;
          word_acc <= word_nx;
        end
      end
      if (state == DRAIN && hs && s.last) done <= 1'b1;
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                 checksum <= '0;
    else if (start_acc)      checksum <= '0;
    else if (we_b != 4'b0)   checksum <= checksum + din_b;
  end
`endif

endmodule

// File: doc/bram_loader.md
# bram_loader

Byte-stream loader that sits directly upstream of the dual-port BRAM's write port (port B). It accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words. It then issues byte-enabled writes (`we_b`/`addr_b`/`din_b`) to consecutive addresses starting at a programmable base. Its purpose is to let a host reload BRAM contents at runtime instead of relying only on the power-up hex image.

## Interface
- `ADDR_W`, 10, word-address width of the target BRAM; depth is 2**ADDR_W words.
- `clk`  in  1  single clock, same domain as the BRAM.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load when idle.
- `base_addr`  in  ADDR_W  first word address, sampled on accepted `start`.
- `s_valid`  in  1  byte available.
- `s_ready`  out  1  loader accepts byte this cycle.
- `s_data`  in  8  byte payload.
- `s_last`  in  1  marks final byte of the load.
- `we_b`  out  4  per-byte write enable to BRAM port B.
- `addr_b`  out  ADDR_W  BRAM port B word address.
- `din_b`  out  32  BRAM port B write data.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on load completion.
- `err`  out  1  sticky overflow flag, cleared by the next accepted `start`.
- `word_count`  out  ADDR_W+1  writes issued in the current load.

## Operation
- The loader has three states: IDLE, LOAD and DRAIN.
- **IDLE**
  - `s_ready`=0.
  - `start`=1 latches `base_addr` into the pointer and clears the lane index, `word_count` and `err`. The next state is LOAD.
- **LOAD**
  - `s_ready`=1.
  - Each handshake (`s_valid & s_ready`) stores `s_data` in lane `idx` (lane 0 = bits 7:0) and sets `mask[idx]`.
  - A write is issued when a byte completes lane 3, or on any byte with `s_last`=1:
    - `we_b` = accumulated mask.
    - `din_b` = assembled word; unfilled lanes are 0.
    - `addr_b` = pointer.
  - After issuing a write, the loader clears `idx` and the mask, increments the pointer and increments `word_count`.
  - A write issued on `s_last` returns the state to IDLE.
- **Overflow**
  - Condition: a full-word write (no `s_last`) lands at address 2**ADDR_W-1.
  - The pointer does not wrap. The loader sets `err`=1 and moves to DRAIN.
- **DRAIN**
  - `s_ready`=1 and `we_b`=0. Incoming bytes are discarded.
  - The byte carrying `s_last` returns the state to IDLE and pulses `done`.
- `start` while `busy`=1 is ignored.
- `s_last` on lane 3 produces a normal full write (`we_b`=4'hF).
- A load of zero bytes is not possible: a load ends only via `s_last`.
- `s_valid` gaps stall assembly indefinitely. No timeout.

## Timing
- Reset values: `s_ready`=0, `we_b`=0, `addr_b`=0, `din_b`=0, `busy`=0, `done`=0, `err`=0, `word_count`=0, state IDLE.
- Mid-operation reset: any partial word is discarded and no write is issued.
- All outputs are registered.
- `start` in cycle n → `busy`=1 and `s_ready`=1 in cycle n+1.
- A byte completing a word accepted in cycle n → `we_b`≠0 in cycle n+1 for exactly one cycle, with `addr_b`/`din_b` valid in the same cycle.
- Throughput is 1 byte/cycle sustained, with no bubble around writes.
- `s_last` byte accepted in cycle n:
  - final write, `done`=1 and `busy`=0 all in cycle n+1;
  - `s_ready`=0 from cycle n+1.
- `word_count` reflects the write in the cycle it is presented (n+1).
- `addr_b` and `din_b` hold their last values when `we_b`=0.
- BRAM read-during-write behaviour on port B is the BRAM's concern. The loader never reads.

## Configuration
- `BRAM_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` (32 bits), reset 0 and cleared on accepted `start`.
  - Each write adds `din_b` (masked lanes as 0) modulo 2**32.
  - The updated value is visible the cycle after the write.
  - DRAIN-discarded bytes are not summed.
- Undefined: the `checksum` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Full-word load:** `base_addr`=0x010, bytes 01..08 back-to-back with `s_last` on 08 → writes (0x010, F, 0x04030201) then (0x011, F, 0x08070605); `done` together with the second write; `word_count`=2.
- **Partial tail:** base 0x3F0, bytes AA,BB,CC with `s_last` on CC → single write (0x3F0, `we_b`=4'b0111, 0x00CCBBAA).
- **Overflow:** base 0x3FF, 6 bytes 11..16, `s_last` on 16 → one write (0x3FF, F, 0x14131211); `err`=1; bytes 15,16 dropped; `done` after 16; the next `start` clears `err`.
- **Stalls and ignored start:** `s_valid` toggled every other cycle during a 4-byte load, `start` pulsed mid-load → exactly one write, base unchanged, no restart.
- **Mid-operation reset:** `rst` after 2 of 4 bytes → no write issued; all outputs return to reset values the next cycle.
- **Checksum (macro defined):** the full-word load scenario → `checksum`=0x0C0A0806.
